// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT datapath: default size, AGU state
// encoding and the bit-rotate helper used for in-place butterfly addressing.
package fft_pkg;

  localparam int FFT_M    = 9;
  localparam int FFT_N    = 1 << FFT_M;
  localparam int ROTL_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } fft_agu_state_t;

  // Left rotate of the low m bits of value by amount (amount < m <= ROTL_MAX).
  function automatic logic [ROTL_MAX-1:0] rotl(input logic [ROTL_MAX-1:0] value,
                                               input int amount, input int m);
    logic [ROTL_MAX-1:0] res;
    res = '0;
    for (int b = 0; b < ROTL_MAX; b++) begin
      if (b < m) res[(b + amount) % m] = value[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_agu_rotate.sv
// Combinational M-bit barrel rotate; maps the linear butterfly index onto the
// in-place address for the current stage.
module fft_agu_rotate
  import fft_pkg::*;
#(
  parameter int M  = FFT_M,
  parameter int SW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]  value,
  input  logic [SW-1:0] amount,
  output logic [M-1:0]  result
);

  assign result = M'(rotl(ROTL_MAX'(value), int'(amount), M));

endmodule

// File: rtl/fft_agu.sv
// Address generator / sequencer for the in-place radix-2 FFT: walks M stages of
// N/2 butterflies, issuing reads each cycle and the matching writes one cycle later.
module fft_agu
  import fft_pkg::*;
#(
  parameter int M = FFT_M
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] rd_adr_a,
  output logic [M-1:0] rd_adr_b,
  output logic [M-2:0] tw_adr,
  output logic         rd_bank,
  output logic [M-1:0] wr_adr_a,
  output logic [M-1:0] wr_adr_b,
  output logic         wr_bank,
  output logic         we,
  output logic         result_bank
);

  localparam int SW = (M > 1) ? $clog2(M) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(M - 1);
  localparam logic [M-2:0]  LAST_BFLY  = '1;
  localparam logic [M-2:0]  TW_ONES    = '1;

  fft_agu_state_t state_reg, state_next;
  logic [SW-1:0]  stage_reg;
  logic [M-2:0]   bfly_reg;
  logic           last_bfly;
  logic [M-2:0]   tw_mask;
  logic [M-1:0]   rot_in  [2];
  logic [M-1:0]   rot_out [2];

  assign result_bank = (M % 2) == 1;
  assign last_bfly   = (stage_reg == LAST_STAGE) && (bfly_reg == LAST_BFLY);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (last_bfly) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Counters sit at zero while idle, so they are already cleared on entry to RUN.
  always_ff @(posedge clk) begin
    if (reset || state_reg == ST_IDLE) begin
      stage_reg <= '0;
      bfly_reg  <= '0;
    end else if (state_reg == ST_RUN) begin
      bfly_reg <= bfly_reg + 1'b1;
      if (bfly_reg == LAST_BFLY) stage_reg <= stage_reg + 1'b1;
    end
  end

  // Butterfly j reads points 2j and 2j+1, rotated left by the stage number.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rot
      assign rot_in[gi] = {bfly_reg, 1'(gi)};
      fft_agu_rotate #(.M(M), .SW(SW)) u_rot (
        .value  (rot_in[gi]),
        .amount (stage_reg),
        .result (rot_out[gi])
      );
    end
  endgenerate

  // Stage i keeps only the top i bits of j as the twiddle index.
  assign tw_mask = TW_ONES << (LAST_STAGE - stage_reg);

  always_comb begin
    busy     = (state_reg == ST_RUN) || (state_reg == ST_FLUSH);
    done     = (state_reg == ST_DONE);
    rd_adr_a = '0;
    rd_adr_b = '0;
    tw_adr   = '0;
    rd_bank  = 1'b0;
    if (state_reg == ST_RUN) begin
      rd_adr_a = rot_out[0];
      rd_adr_b = rot_out[1];
      tw_adr   = bfly_reg & tw_mask;
      rd_bank  = stage_reg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_adr_a <= '0;
      wr_adr_b <= '0;
      wr_bank  <= 1'b0;
      we       <= 1'b0;
    end else begin
      wr_adr_a <= rd_adr_a;
      wr_adr_b <= rd_adr_b;
      wr_bank  <= ~rd_bank;
      we       <= (state_reg == ST_RUN);
    end
  end

endmodule
